// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: FSM states, the IF/ID entry layout and PC arithmetic.
package fetch_pkg;
    localparam int unsigned     XLEN           = 32;
    localparam logic [XLEN-1:0] PC_STEP        = 32'd4;
    localparam logic [XLEN-1:0] PC_ALIGN_MASK  = 32'hFFFF_FFFC;
    localparam logic [XLEN-1:0] NOP_INSTR_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        ISSUE,
        WAIT,
        HOLD
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_entry_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry pc/instr holding register that catches a fetch response while IF/ID is stalled.
// Loads on i_load, empties on i_clear (clear wins); contents are visible the cycle after load.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_load,
    input  logic      i_clear,
    input  if_entry_t i_entry,
    output logic      o_valid,
    output if_entry_t o_entry
);
    logic      r_valid;
    if_entry_t r_entry;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_entry <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_entry <= i_entry;
        end
    end

    assign o_valid = r_valid;
    assign o_entry = r_entry;
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: boot delay, one outstanding imem request, redirect squashing, IF/ID register + skid.
// Two cycles per instruction at 1-cycle memory latency; stall holds IF/ID and parks fetch in HOLD.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     BOOT_DELAY = 4,
    parameter logic [XLEN-1:0] NOP_INSTR  = NOP_INSTR_WORD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_in,
    input  logic            jump_en,
    input  logic [XLEN-1:0] pc_jump_addr,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_rvalid,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr
);
    localparam int unsigned    BCW       = (BOOT_DELAY < 1) ? 1 : $clog2(BOOT_DELAY + 1);
    localparam logic [BCW-1:0] BOOT_LAST = BCW'(BOOT_DELAY);

    fetch_state_t    r_state, w_state_nxt;
    logic [BCW-1:0]  r_boot_cnt;
    logic [XLEN-1:0] r_fetch_pc;
    logic            r_pending, w_pending_nxt;
    logic            r_discard, w_discard_nxt;
    logic            r_if_valid;
    logic [XLEN-1:0] r_if_pc, r_if_instr;

    logic            w_consume, w_out_free, w_rsp;
    logic            w_req, w_out_load, w_out_unskid, w_skid_load, w_pc_inc;
    logic            w_skid_vld;
    if_entry_t       w_rsp_entry, w_skid_entry;

    assign w_consume   = r_if_valid & ~stall_in;
    assign w_out_free  = ~r_if_valid | w_consume;
    // A response only counts against a request this controller actually issued.
    assign w_rsp       = imem_rvalid & r_pending;
    assign w_rsp_entry = '{pc: r_fetch_pc, instr: imem_rdata};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= BOOT;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_req         = 1'b0;
        w_out_load    = 1'b0;
        w_out_unskid  = 1'b0;
        w_skid_load   = 1'b0;
        w_pc_inc      = 1'b0;
        w_pending_nxt = w_rsp ? 1'b0 : r_pending;
        w_discard_nxt = r_discard;
        unique case (r_state)
            BOOT: begin
                if (r_boot_cnt == BOOT_LAST) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                w_req         = 1'b1;
                w_pending_nxt = 1'b1;
                w_state_nxt   = WAIT;
                if (jump_en) w_discard_nxt = 1'b1;
            end
            WAIT: begin
                if (jump_en) begin
                    if (w_rsp) begin
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = ISSUE;
                    end else if (r_pending) begin
                        w_discard_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = ISSUE;
                    end
                end else if (w_rsp) begin
                    w_pc_inc = ~r_discard;
                    if (r_discard) begin
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = ISSUE;
                    end else if (w_out_free) begin
                        w_out_load  = 1'b1;
                        w_state_nxt = ISSUE;
                    end else begin
                        w_skid_load = 1'b1;
                        w_state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (jump_en) begin
                    w_state_nxt = ISSUE;
                end else if (w_consume && w_skid_vld) begin
                    w_out_unskid = 1'b1;
                    w_state_nxt  = ISSUE;
                end
            end
            default: w_state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_boot_cnt <= '0;
            r_fetch_pc <= RESET_PC;
            r_pending  <= 1'b0;
            r_discard  <= 1'b0;
        end else begin
            if (r_state == BOOT) r_boot_cnt <= r_boot_cnt + BCW'(1);
            r_pending <= w_pending_nxt;
            r_discard <= w_discard_nxt;
            if (jump_en)       r_fetch_pc <= pc_jump_addr & PC_ALIGN_MASK;
            else if (w_pc_inc) r_fetch_pc <= r_fetch_pc + PC_STEP;
        end
    end

    // IF/ID register: a redirect flushes it, otherwise it refills from memory or skid, or drains.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_valid <= 1'b0;
            r_if_pc    <= RESET_PC;
            r_if_instr <= NOP_INSTR;
        end else if (jump_en) begin
            r_if_valid <= 1'b0;
            r_if_instr <= NOP_INSTR;
        end else if (w_out_load) begin
            r_if_valid <= 1'b1;
            r_if_pc    <= r_fetch_pc;
            r_if_instr <= imem_rdata;
        end else if (w_out_unskid) begin
            r_if_valid <= 1'b1;
            r_if_pc    <= w_skid_entry.pc;
            r_if_instr <= w_skid_entry.instr;
        end else if (w_consume) begin
            r_if_valid <= 1'b0;
            r_if_instr <= NOP_INSTR;
        end
    end

    fetch_skid_buf u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_clear (jump_en | w_out_unskid),
        .i_entry (w_rsp_entry),
        .o_valid (w_skid_vld),
        .o_entry (w_skid_entry)
    );

    assign imem_req  = w_req;
    assign imem_addr = r_fetch_pc;
    assign if_valid  = r_if_valid;
    assign if_pc     = r_if_pc;
    assign if_instr  = r_if_instr;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboarded bench for fetch_ctrl: directed phases push expected requests/instructions,
// a negedge monitor pops them on every imem_req and every IF/ID consume.
module tb_fetch_ctrl;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_if_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_in = 1'b0;
    logic        jump_en = 1'b0;
    logic [31:0] pc_jump_addr = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    logic [31:0] exp_addr_q[$];
    exp_if_t     exp_if_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          mem_lat = 1;
    int          boot_cnt;

    fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stall_in     (stall_in),
        .jump_en      (jump_en),
        .pc_jump_addr (pc_jump_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_rvalid  (imem_rvalid),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_instr     (if_instr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   {31'b0, imem_req}, 32'h0);
        chk({tag, "_addr"},  imem_addr,         32'h0);
        chk({tag, "_valid"}, {31'b0, if_valid}, 32'h0);
        chk({tag, "_pc"},    if_pc,             32'h0);
        chk({tag, "_instr"}, if_instr,          32'h0000_0013);
    endtask

    task automatic push_if(input logic [31:0] pc, input logic [31:0] instr);
        exp_if_q.push_back('{pc: pc, instr: instr});
    endtask

    task automatic wait_first_req(output int cnt);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (imem_req) break;
        end
    endtask

    // Memory: answers the last request mem_lat cycles later; data = addr ^ 32'hA500_0000.
    initial begin
        logic [31:0] maddr;
        int          mcnt;
        maddr = 32'h0;
        mcnt = 0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                maddr = imem_addr;
                mcnt = mem_lat;
            end
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata = maddr ^ 32'hA500_0000;
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        exp_if_t     e;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                if (exp_addr_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_req: addr %h, none expected (t=%0t)", imem_addr, $time);
                end else begin
                    a = exp_addr_q.pop_front();
                    chk("req_addr", imem_addr, a);
                end
            end
            if (if_valid && !stall_in) begin
                if (exp_if_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_consume: pc %h instr %h, none expected (t=%0t)", if_pc, if_instr, $time);
                end else begin
                    e = exp_if_q.pop_front();
                    chk("consume_pc", if_pc, e.pc);
                    chk("consume_instr", if_instr, e.instr);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("por");

        foreach (a_init[i]) exp_addr_q.push_back(a_init[i]);
        push_if(32'h0000_0000, 32'hA500_0000);
        push_if(32'h0000_0004, 32'hA500_0004);
        push_if(32'h0000_0008, 32'hA500_0008);
        push_if(32'h0000_000C, 32'hA500_000C);
        push_if(32'h0000_0010, 32'hA500_0010);
        push_if(32'h0000_0014, 32'hA500_0014);
        rst = 1'b1;

        // Boot: first request five cycles after release, at RESET_PC.
        wait_first_req(boot_cnt);
        chk("boot_cycles", boot_cnt, 32'd5);

        // Stall for 6 cycles while pc 4 is presented; pc 8 lands in the skid.
        repeat (4) @(posedge clk);
        #1 stall_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'b0, if_valid}, 32'h1);
            chk("stall_pc", if_pc, 32'h4);
            if (i >= 2) chk("hold_no_req", {31'b0, imem_req}, 32'h0);
        end
        @(posedge clk);
        #1 stall_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("unskid_valid", {31'b0, if_valid}, 32'h1);
        chk("unskid_pc", if_pc, 32'h8);
        @(negedge clk);
        chk("stream_gap", {31'b0, if_valid}, 32'h0);
        @(negedge clk);
        chk("stream_pc12", if_pc, 32'hC);

        // Park, then release with 3-cycle memory and redirect one cycle after the request.
        repeat (2) @(posedge clk);
        #1 stall_in = 1'b1;
        repeat (4) @(posedge clk);
        #1 stall_in = 1'b0;
        mem_lat = 3;
        repeat (2) @(posedge clk);
        #1 jump_en = 1'b1;
        pc_jump_addr = 32'h0000_0100;
        exp_addr_q.push_back(32'h0000_0104);
        exp_addr_q.push_back(32'h0000_0200);
        push_if(32'h0000_0100, 32'hA500_0100);
        @(posedge clk);
        #1 jump_en = 1'b0;
        @(negedge clk);
        chk("jump_flush_valid", {31'b0, if_valid}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("redirect_req", {31'b0, imem_req}, 32'h1);
        chk("redirect_addr", imem_addr, 32'h0000_0100);
        chk("stale_dropped", {31'b0, if_valid}, 32'h0);

        // Jump, stall and rvalid together; target's low bits are cleared.
        repeat (7) @(posedge clk);
        #1 jump_en = 1'b1;
        stall_in = 1'b1;
        pc_jump_addr = 32'h0000_0203;
        @(posedge clk);
        #1 jump_en = 1'b0;
        @(negedge clk);
        chk("coinc_req", {31'b0, imem_req}, 32'h1);
        chk("coinc_addr", imem_addr, 32'h0000_0200);
        chk("coinc_valid", {31'b0, if_valid}, 32'h0);
        exp_addr_q.push_back(32'h0000_0204);
        exp_addr_q.push_back(32'h0000_0208);
        push_if(32'h0000_0200, 32'hA500_0200);
        push_if(32'h0000_0204, 32'hA500_0204);
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("park_valid", {31'b0, if_valid}, 32'h1);
        chk("park_pc", if_pc, 32'h0000_0200);
        chk("park_instr", if_instr, 32'hA500_0200);
        chk("park_no_req", {31'b0, imem_req}, 32'h0);

        // Release, then reset while the request for 0x208 is outstanding.
        @(posedge clk);
        #1 stall_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk_reset("mid_wait");
        stall_in = 1'b1;
        exp_addr_q.push_back(32'h0000_0000);
        exp_addr_q.push_back(32'h0000_0004);
        @(posedge clk);
        #1 rst = 1'b1;
        wait_first_req(boot_cnt);
        chk("reboot_cycles", boot_cnt, 32'd5);
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("reboot_valid", {31'b0, if_valid}, 32'h1);
        chk("reboot_pc", if_pc, 32'h0);
        chk("reboot_instr", if_instr, 32'hA500_0000);
        chk("reboot_no_req", {31'b0, imem_req}, 32'h0);

        // Redirect from HOLD to the top of the address space; the next fetch wraps to 0.
        @(posedge clk);
        #1 jump_en = 1'b1;
        pc_jump_addr = 32'hFFFF_FFFC;
        exp_addr_q.push_back(32'hFFFF_FFFC);
        exp_addr_q.push_back(32'h0000_0000);
        @(posedge clk);
        #1 jump_en = 1'b0;
        @(negedge clk);
        chk("hold_jump_valid", {31'b0, if_valid}, 32'h0);
        chk("hold_jump_instr", if_instr, 32'h0000_0013);
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("wrap_valid", {31'b0, if_valid}, 32'h1);
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_instr", if_instr, 32'h5AFF_FFFC);
        chk("wrap_no_req", {31'b0, imem_req}, 32'h0);

        chk("addr_q_left", exp_addr_q.size(), 32'h0);
        chk("if_q_left", exp_if_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    logic [31:0] a_init[8] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h100};
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences instruction fetch between the pipeline control signals (stall, jump redirect) and an instruction memory with a req/rvalid handshake and variable latency.
- Owns the fetch PC, a post-reset boot delay, one outstanding memory request, redirect squashing, and a one-entry skid buffer.
- Drives the IF/ID boundary with a valid/pc/instruction triple that holds while the pipeline stalls.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BOOT_DELAY, 4, idle cycles after reset release before the first request (0 allowed).
- NOP_INSTR, 32'h0000_0013, value of if_instr when nothing is valid (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall_in  in  1  downstream stall; IF/ID must hold.
- jump_en  in  1  redirect/flush request, one cycle.
- pc_jump_addr  in  32  redirect target.
- imem_req  out  1  single-cycle fetch request strobe.
- imem_addr  out  32  fetch address; valid while imem_req=1.
- imem_rdata  in  32  instruction data; sampled when imem_rvalid=1.
- imem_rvalid  in  1  response strobe for the outstanding request.
- if_valid  out  1  if_pc/if_instr hold a live instruction.
- if_pc  out  32  PC of the presented instruction.
- if_instr  out  32  presented instruction.

Behaviour:
- Reset (rst=0, async) values:
  - state=BOOT, boot_cnt=0, fetch_pc=RESET_PC, pending=0, discard=0, skid_valid=0.
  - imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=RESET_PC, if_instr=NOP_INSTR.
- Reset asserted mid-operation aborts everything. Any later rvalid for a pre-reset request is ignored, because pending=0.
- Consume rule: the IF/ID entry is taken in any cycle with if_valid=1 and stall_in=0.
- The output register loads only when it is empty or being consumed. Otherwise data goes to the skid buffer.
- States:
  - BOOT: boot_cnt increments each cycle. Go to ISSUE when boot_cnt==BOOT_DELAY (the cycle after reset release if 0).
  - ISSUE: imem_req=1 and imem_addr=fetch_pc for exactly one cycle; pending<=1; go to WAIT. Enter ISSUE only when skid_valid=0.
  - WAIT: imem_req=0. On imem_rvalid with discard=0:
    - output free → if_valid<=1, if_pc<=fetch_pc, if_instr<=imem_rdata, fetch_pc<=fetch_pc+4, go to ISSUE.
    - output occupied and stalled → data goes to skid, fetch_pc+=4, go to HOLD.
    - On rvalid with discard=1 → drop the data, discard<=0, go to ISSUE. fetch_pc already holds the jump target.
  - HOLD: wait for a consume, then move skid to the output register, skid_valid<=0, go to ISSUE.
- Throughput: one instruction per 2 cycles with 1-cycle memory latency. Memory latency adds cycles 1:1.
- Jump (jump_en=1) has priority over stall and over rvalid in the same cycle:
  - fetch_pc<=pc_jump_addr with bits [1:0] forced to 0.
  - if_valid<=0, if_instr<=NOP_INSTR, skid_valid<=0.
  - If pending and rvalid is not in this cycle → discard<=1, stay in WAIT.
  - If rvalid coincides → drop the data, go to ISSUE.
  - From HOLD or ISSUE (request issued this cycle) → handled like WAIT: a request issued in the ISSUE cycle sets discard.
  - From BOOT: only fetch_pc updates; boot countdown continues.
- imem_rvalid with pending=0 is ignored.
- fetch_pc arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 → 32'h0.
- if_pc/if_instr stay constant while if_valid=1 and stall_in=1.

Decomposition:
- Shared package fetch_pkg: state enum (BOOT, ISSUE, WAIT, HOLD), NOP_INSTR constant, PC_STEP=4, instruction/address width constant 32.
- One natural sub-module: fetch_skid_buf. It holds the one-entry pc/instr/valid register with load/unload control.

Test Plan:
- Boot: release rst, BOOT_DELAY=4, 1-cycle memory → first imem_req 5 cycles after release with imem_addr=0; if_valid rises with if_pc=0, if_instr=mem[0].
- Streaming: no stall, memory returns addr-encoded data → if_pc sequence 0,4,8,12, one instruction per 2 cycles, no gaps or repeats.
- Stall with skid: hold stall_in=1 for 6 cycles with if_valid=1 → if_pc=4 held constant; the next instruction (pc 8) goes to the skid; no imem_req during HOLD; release → pc 8 presented the next cycle.
- Redirect during outstanding request: 3-cycle memory latency, jump_en with target 0x100 one cycle after req → stale data dropped, if_valid=0; the next imem_req has addr 0x100.
- Coincident events: jump_en, stall_in and imem_rvalid in the same cycle, target 0x203 → data dropped, next imem_addr=0x200, if_valid=0.
- Async reset mid-WAIT, then late rvalid → outputs go to reset values immediately; the late rvalid is ignored; boot sequence restarts from RESET_PC.
